arb_client4: RTL

ARB_CLIENT4 -- requirements
Module: arb_client4

---
 rtl/arb_client4_pkg.sv | 26 ++
 rtl/arb_client4_pend_counter.sv | 41 ++++
 rtl/arb_client4.sv | 75 +++++++
 3 files changed

// File: rtl/arb_client4_pkg.sv
// Shared constants and one-hot helpers
// for the four-client arbiter front end.
package arb_client4_pkg;

  localparam int NCLIENT = 4;
  localparam int IDX_W   = 2;

  function automatic logic is_onehot(
    input logic [NCLIENT-1:0] v
  );
    return (v != '0) &&
           ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [NCLIENT-1:0] v
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_client4_pend_counter.sv
// Saturating pending-request counter
// for one client; inc and dec together cancel.
module pend_counter #(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       nonzero,
  output logic                       ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) ovf = 1'b1;
      else count_d = count_q + CW'(1);
    end else if (dec && !inc) begin
      if (count_q != '0)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/arb_client4.sv
// Request front end for a lowest-set-bit arbiter:
// per-client pending counts, grant check, status flags.
module arb_client4
  import arb_client4_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NCLIENT-1:0] REQ_PULSE,
  input  logic [NCLIENT-1:0] GNT,
  output logic [NCLIENT-1:0] REQ,
  output logic               VALID,
  output logic [IDX_W-1:0]   IDX,
  output logic               OVF,
  output logic               ERR
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [NCLIENT-1:0] nz;
  logic [NCLIENT-1:0] ovf_ev;
  logic [NCLIENT-1:0] dec;
  logic [CW-1:0]      cnt [NCLIENT];

  logic               legal;
  logic               valid_d, valid_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               ovf_d, ovf_q;
  logic               err_d, err_q;

  for (genvar i = 0; i < NCLIENT; i++) begin : g_pc
    pend_counter #(.DEPTH(DEPTH)) u_pc (
      .clk     (CLK),
      .rst     (RESET),
      .inc     (REQ_PULSE[i]),
      .dec     (dec[i]),
      .count   (cnt[i]),
      .nonzero (nz[i]),
      .ovf     (ovf_ev[i])
    );
  end

  // A grant only counts when it hits a client that is asking
  assign legal = is_onehot(GNT) && ((GNT & nz) != '0);
  assign dec   = legal ? GNT : '0;

  always_comb begin
    valid_d = legal;
    idx_d   = legal ? oh2idx(GNT) : idx_q;
    ovf_d   = ovf_q | (|ovf_ev);
    err_d   = err_q | ((GNT != '0) && !legal);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign REQ   = nz;
  assign VALID = valid_q;
  assign IDX   = idx_q;
  assign OVF   = ovf_q;
  assign ERR   = err_q;

endmodule
